// File: rtl/gdp_pkg.sv
// Shared definitions for the generic deparser (gdp): flit type codes,
// field widths, FSM state encodings and the PHV chunk selector.
package gdp_pkg;

  localparam int MD_W        = 256;
  localparam int PHV_W       = 1024;
  localparam int FLIT_W      = 134;
  localparam int CHUNK_W     = 128;
  localparam int PHV_FLITS   = 8;
  localparam int MD_DROP_BIT = 127;

  // Flit type field, bits [133:132]
  localparam logic [1:0] FLIT_HEAD = 2'b01;
  localparam logic [1:0] FLIT_MID  = 2'b11;
  localparam logic [1:0] FLIT_TAIL = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } gdp_state_e;

  // PHV chunk carried by flit index fidx (2..9); fidx 2 is the top chunk.
  function automatic logic [CHUNK_W-1:0] phv_chunk(input logic [PHV_W-1:0] phv,
                                                   input logic [7:0]       fidx);
    logic [CHUNK_W-1:0] r;
    r = '0;
    for (int k = 0; k < PHV_FLITS; k++) begin
      if (fidx == 8'(9 - k)) r = phv[k*CHUNK_W +: CHUNK_W];
    end
    return r;
  endfunction

endpackage

// File: rtl/gdp_fwft_fifo.sv
// First-word-fall-through FIFO: head entry visible on dout_o while non-empty.
// Writes to a full FIFO are discarded and flagged on ovf_o for one cycle.
// Emptiness/fullness are derived by the user from count_o.
module gdp_fwft_fifo #(
  parameter int W  = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_i,
  input  logic [W-1:0]  din_i,
  input  logic          rd_i,
  output logic [W-1:0]  dout_o,
  output logic [AW:0]   count_o,
  output logic          ovf_o
);

  localparam int          DEPTH_I = 1 << AW;
  localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

  logic [W-1:0]  mem_q [DEPTH_I];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   count_q, count_d;
  logic          full, empty, do_wr, do_rd;

  assign full    = (count_q == DEPTH);
  assign empty   = (count_q == '0);
  assign do_wr   = wr_i && !full;
  assign do_rd   = rd_i && !empty;
  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign ovf_o   = wr_i && full;

  // Occupancy next-state
  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  // Pointers and occupancy, flushed by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + 1'b1;
      if (do_rd) rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wptr_q] <= din_i;
  end

endmodule

// File: rtl/gdp.sv
// Generic deparser top. Rebuilds the flit stream: MD in flits 0-1, PHV in
// flits 2-9, payload from flit 10 on. Store-and-forward: a packet starts
// only once its packet-complete strobe has been seen.
// Optional build macro GDP_MD_STRIP_EN: MD flits are consumed but not emitted,
// and flit 2 is re-typed as the head.
// Handshake: pktout_ready=1 during a cycle lets one flit pop in that cycle;
// the rebuilt flit appears with pktout_data_wr=1 on the following cycle.
module gdp
  import gdp_pkg::*;
#(
  parameter int DATA_AW      = 8,
  parameter int Q_AW         = 2,
  parameter int DATA_ALF_GAP = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MD_W-1:0]     in_gdp_md,
  input  logic                in_gdp_md_wr,
  output logic                out_gdp_md_alf,
  input  logic [PHV_W-1:0]    in_gdp_phv,
  input  logic                in_gdp_phv_wr,
  output logic                out_gdp_phv_alf,
  input  logic [FLIT_W-1:0]   in_gdp_data,
  input  logic                in_gdp_data_wr,
  input  logic                in_gdp_valid_wr,
  input  logic                in_gdp_valid,
  output logic                out_gdp_data_alf,
  output logic [FLIT_W-1:0]   pktout_data,
  output logic                pktout_data_wr,
  output logic                pktout_valid_wr,
  output logic                pktout_valid,
  input  logic                pktout_ready,
  input  logic [FLIT_W-1:0]   cin_gdp_data,
  input  logic                cin_gdp_data_wr,
  output logic                cout_gdp_ready,
  output logic [FLIT_W-1:0]   cout_gdp_data,
  output logic                cout_gdp_data_wr,
  input  logic                cin_gdp_ready,
  output logic [31:0]         gdp_status
);

  localparam logic [DATA_AW:0] DATA_DEPTH = {1'b1, {DATA_AW{1'b0}}};
  localparam logic [DATA_AW:0] ALF_GAP    = DATA_ALF_GAP[DATA_AW:0];
  localparam logic [Q_AW:0]    Q_ALF      = {1'b0, {Q_AW{1'b1}}};

  // Queue heads and occupancies
  logic [MD_W-1:0]   md_head;
  logic [PHV_W-1:0]  phv_head;
  logic [0:0]        vld_head;
  logic [FLIT_W-1:0] flit_head;
  logic [Q_AW:0]     md_cnt, phv_cnt, vld_cnt;
  logic [DATA_AW:0]  data_cnt;
  logic              md_ovf, phv_ovf, vld_ovf, data_ovf;

  // Control
  gdp_state_e        state_q, state_d;
  logic [7:0]        fidx_q;
  logic [DATA_AW:0]  pkt_cnt_q, pkt_cnt_d;
  logic              ovf_sticky_q;
  logic              flit_pop, q_pop, emit, strip_skip, pkt_avail, flit_is_tail;
  logic [FLIT_W-1:0] out_flit;

  // Registered egress
  logic [FLIT_W-1:0] pktout_data_q;
  logic              pktout_data_wr_q, pktout_valid_wr_q, pktout_valid_q;

  gdp_fwft_fifo #(.W(MD_W), .AW(Q_AW)) u_md_q (
    .clk(clk), .rst_n(rst_n), .wr_i(in_gdp_md_wr), .din_i(in_gdp_md), .rd_i(q_pop),
    .dout_o(md_head), .count_o(md_cnt), .ovf_o(md_ovf));

  gdp_fwft_fifo #(.W(PHV_W), .AW(Q_AW)) u_phv_q (
    .clk(clk), .rst_n(rst_n), .wr_i(in_gdp_phv_wr), .din_i(in_gdp_phv), .rd_i(q_pop),
    .dout_o(phv_head), .count_o(phv_cnt), .ovf_o(phv_ovf));

  gdp_fwft_fifo #(.W(1), .AW(Q_AW)) u_vld_q (
    .clk(clk), .rst_n(rst_n), .wr_i(in_gdp_valid_wr), .din_i(in_gdp_valid), .rd_i(q_pop),
    .dout_o(vld_head), .count_o(vld_cnt), .ovf_o(vld_ovf));

  gdp_fwft_fifo #(.W(FLIT_W), .AW(DATA_AW)) u_data_q (
    .clk(clk), .rst_n(rst_n), .wr_i(in_gdp_data_wr), .din_i(in_gdp_data), .rd_i(flit_pop),
    .dout_o(flit_head), .count_o(data_cnt), .ovf_o(data_ovf));

  assign flit_is_tail = (flit_head[133:132] == FLIT_TAIL);
  assign pkt_avail    = (md_cnt != '0) && (phv_cnt != '0) && (vld_cnt != '0) &&
                        (pkt_cnt_q != '0);

`ifdef GDP_MD_STRIP_EN
  assign strip_skip = (fidx_q < 8'd2);
`else
  assign strip_skip = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: choose SEND/DROP once a full packet is available
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pkt_avail)
          state_d = (md_head[MD_DROP_BIT] || !vld_head[0]) ? ST_DROP : ST_SEND;
      end
      ST_SEND, ST_DROP: begin
        if (flit_pop && flit_is_tail) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: flit pop, emit and per-packet queue pop
  always_comb begin
    flit_pop = 1'b0;
    emit     = 1'b0;
    case (state_q)
      ST_SEND: begin
        flit_pop = pktout_ready && (data_cnt != '0);
        emit     = flit_pop && !strip_skip;
      end
      ST_DROP: flit_pop = (data_cnt != '0);
      default: ;
    endcase
    q_pop = flit_pop && flit_is_tail;
  end

  // Output flit mux: low 128 bits replaced by MD/PHV for the first ten flits
  always_comb begin
    out_flit = flit_head;
    if (fidx_q == 8'd0)       out_flit[127:0] = md_head[127:0];
    else if (fidx_q == 8'd1)  out_flit[127:0] = md_head[255:128];
    else if (fidx_q < 8'd10)  out_flit[127:0] = phv_chunk(phv_head, fidx_q);
`ifdef GDP_MD_STRIP_EN
    if (fidx_q == 8'd2) out_flit[133:132] = FLIT_HEAD;
`endif
  end

  // Flit index within packet, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fidx_q <= '0;
    end else if (state_q == ST_IDLE) begin
      fidx_q <= '0;
    end else if (flit_pop && fidx_q != 8'hFF) begin
      fidx_q <= fidx_q + 1'b1;
    end
  end

  // Completed-packet counter next state
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    case ({in_gdp_valid_wr, q_pop})
      2'b10:   pkt_cnt_d = pkt_cnt_q + 1'b1;
      2'b01:   pkt_cnt_d = pkt_cnt_q - 1'b1;
      default: ;
    endcase
  end

  // Packet counter and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q    <= '0;
      ovf_sticky_q <= 1'b0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      if (md_ovf || phv_ovf || vld_ovf || data_ovf) ovf_sticky_q <= 1'b1;
    end
  end

  // Registered egress; data holds its last value while idle or stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pktout_data_q     <= '0;
      pktout_data_wr_q  <= 1'b0;
      pktout_valid_wr_q <= 1'b0;
      pktout_valid_q    <= 1'b0;
    end else begin
      pktout_data_wr_q  <= emit;
      pktout_valid_wr_q <= emit && flit_is_tail;
      pktout_valid_q    <= emit && flit_is_tail;
      if (emit) pktout_data_q <= out_flit;
    end
  end

  assign pktout_data      = pktout_data_q;
  assign pktout_data_wr   = pktout_data_wr_q;
  assign pktout_valid_wr  = pktout_valid_wr_q;
  assign pktout_valid     = pktout_valid_q;

  assign out_gdp_md_alf   = (md_cnt  >= Q_ALF);
  assign out_gdp_phv_alf  = (phv_cnt >= Q_ALF);
  assign out_gdp_data_alf = ((DATA_DEPTH - data_cnt) <= ALF_GAP);

  assign cout_gdp_data    = cin_gdp_data;
  assign cout_gdp_data_wr = cin_gdp_data_wr;
  assign cout_gdp_ready   = cin_gdp_ready;

  assign gdp_status = {state_q, 25'b0, ovf_sticky_q, out_gdp_data_alf,
                       out_gdp_phv_alf, out_gdp_md_alf, pktout_ready};

endmodule

// File: tb/tb_gdp.sv
// Self-checking bench for gdp: packets are driven with their expected
// output flits queued; a negedge monitor pops and compares emitted flits.
module tb_gdp;
  import gdp_pkg::*;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [MD_W-1:0]    in_gdp_md;
  logic               in_gdp_md_wr;
  logic               out_gdp_md_alf;
  logic [PHV_W-1:0]   in_gdp_phv;
  logic               in_gdp_phv_wr;
  logic               out_gdp_phv_alf;
  logic [FLIT_W-1:0]  in_gdp_data;
  logic               in_gdp_data_wr;
  logic               in_gdp_valid_wr;
  logic               in_gdp_valid;
  logic               out_gdp_data_alf;
  logic [FLIT_W-1:0]  pktout_data;
  logic               pktout_data_wr;
  logic               pktout_valid_wr;
  logic               pktout_valid;
  logic               pktout_ready;
  logic [FLIT_W-1:0]  cin_gdp_data;
  logic               cin_gdp_data_wr;
  logic               cout_gdp_ready;
  logic [FLIT_W-1:0]  cout_gdp_data;
  logic               cout_gdp_data_wr;
  logic               cin_gdp_ready;
  logic [31:0]        gdp_status;

  int checks   = 0;
  int failures = 0;
  int out_cnt  = 0;
  logic [135:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  gdp dut (
    .clk(clk), .rst_n(rst_n),
    .in_gdp_md(in_gdp_md), .in_gdp_md_wr(in_gdp_md_wr), .out_gdp_md_alf(out_gdp_md_alf),
    .in_gdp_phv(in_gdp_phv), .in_gdp_phv_wr(in_gdp_phv_wr), .out_gdp_phv_alf(out_gdp_phv_alf),
    .in_gdp_data(in_gdp_data), .in_gdp_data_wr(in_gdp_data_wr),
    .in_gdp_valid_wr(in_gdp_valid_wr), .in_gdp_valid(in_gdp_valid),
    .out_gdp_data_alf(out_gdp_data_alf),
    .pktout_data(pktout_data), .pktout_data_wr(pktout_data_wr),
    .pktout_valid_wr(pktout_valid_wr), .pktout_valid(pktout_valid),
    .pktout_ready(pktout_ready),
    .cin_gdp_data(cin_gdp_data), .cin_gdp_data_wr(cin_gdp_data_wr),
    .cout_gdp_ready(cout_gdp_ready),
    .cout_gdp_data(cout_gdp_data), .cout_gdp_data_wr(cout_gdp_data_wr),
    .cin_gdp_ready(cin_gdp_ready),
    .gdp_status(gdp_status));

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (pktout_data_wr) begin
        out_cnt++;
        if (exp_q.size() == 0) check_val("unexp_flit", 256'(pktout_data_wr), 256'd0);
        else check_val("flit", {pktout_valid_wr, pktout_valid, pktout_data}, exp_q.pop_front());
      end else if (pktout_valid_wr) begin
        check_val("stray_valid_wr", 256'(pktout_valid_wr), 256'd0);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic send_pkt(input logic [255:0] md, input int n, input logic vld, input logic emit);
    logic [1023:0] phv;
    logic [1:0]    t;
    logic [127:0]  lo_in, lo_exp;
    logic          skip;
    phv = '0;
    for (int f = 2; f < 10; f++) phv[(9-f)*128 +: 128] = 128'hA0 + 128'(f);
    in_gdp_md = md;  in_gdp_md_wr = 1'b1;
    in_gdp_phv = phv; in_gdp_phv_wr = 1'b1;
    tick();
    in_gdp_md_wr = 1'b0; in_gdp_phv_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      t = (i == 0) ? FLIT_HEAD : (i == n-1) ? FLIT_TAIL : FLIT_MID;
      lo_in = 128'hC0 + 128'(i);
      in_gdp_data = {t, 4'h0, lo_in};
      in_gdp_data_wr = 1'b1;
      if (i == 0)      lo_exp = md[127:0];
      else if (i == 1) lo_exp = md[255:128];
      else if (i < 10) lo_exp = 128'hA0 + 128'(i);
      else             lo_exp = lo_in;
      skip = 1'b0;
`ifdef GDP_MD_STRIP_EN
      if (i < 2) skip = 1'b1;
      if (i == 2) t = FLIT_HEAD;
`endif
      if (emit && !skip) exp_q.push_back({(i == n-1), (i == n-1), t, 4'h0, lo_exp});
      tick();
    end
    in_gdp_data_wr = 1'b0;
    in_gdp_valid = vld; in_gdp_valid_wr = 1'b1;
    tick();
    in_gdp_valid_wr = 1'b0; in_gdp_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check_val("drain", 256'(exp_q.size()), 256'd0);
  endtask

  task automatic wait_out(input int target, input int budget);
    int n;
    n = 0;
    while (out_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_val("wait_out", 256'(out_cnt >= target), 256'd1);
  endtask

  logic [255:0] md_ones, md_drop, md_rand;
  logic [133:0] cfg;
  int base;

  initial begin
    rst_n = 1'b0;
    in_gdp_md = '0; in_gdp_md_wr = 1'b0; in_gdp_phv = '0; in_gdp_phv_wr = 1'b0;
    in_gdp_data = '0; in_gdp_data_wr = 1'b0; in_gdp_valid_wr = 1'b0; in_gdp_valid = 1'b0;
    pktout_ready = 1'b0; cin_gdp_data = '0; cin_gdp_data_wr = 1'b0; cin_gdp_ready = 1'b0;
    md_ones = {64{4'h1}};
    md_drop = md_ones | (256'd1 << 127);
    md_rand = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    md_rand[127] = 1'b0;
    repeat (3) tick();

    // reset state
    check_val("rst_data", 256'(pktout_data), 256'd0);
    check_val("rst_strobes", {pktout_data_wr, pktout_valid_wr, pktout_valid}, 256'd0);
    check_val("rst_status", 256'(gdp_status), 256'd0);
    check_val("rst_alf", {out_gdp_md_alf, out_gdp_phv_alf, out_gdp_data_alf}, 256'd0);
    rst_n = 1'b1;
    tick();

    // config pass-through
    cfg = {6'h2A, $urandom, $urandom, $urandom, $urandom};
    cin_gdp_data = cfg; cin_gdp_data_wr = 1'b1; cin_gdp_ready = 1'b1;
    #1;
    check_val("cfg_pass", {cout_gdp_data, cout_gdp_data_wr, cout_gdp_ready}, {cfg, 1'b1, 1'b1});
    cin_gdp_data_wr = 1'b0; cin_gdp_ready = 1'b0;

    // 12-flit packet
    pktout_ready = 1'b1;
    send_pkt(md_ones, 12, 1'b1, 1'b1);
    wait_drain(200);
    check_val("pkt_cnt_12", 256'(dut.pkt_cnt_q), 256'd0);
    check_val("state_idle_12", 256'(gdp_status[31:30]), 256'd0);

    // short 4-flit packet with random MD
    send_pkt(md_rand, 4, 1'b1, 1'b1);
    wait_drain(200);
    check_val("md_q_empty", 256'(dut.md_cnt), 256'd0);
    check_val("phv_q_empty", 256'(dut.phv_cnt), 256'd0);
    check_val("data_q_empty", 256'(dut.data_cnt), 256'd0);

    // dropped packets (MD drop bit, invalid flag) then a normal one
    send_pkt(md_drop, 6, 1'b1, 1'b0);
    send_pkt(md_ones, 5, 1'b0, 1'b0);
    send_pkt(md_rand, 3, 1'b1, 1'b1);
    wait_drain(300);
    check_val("pkt_cnt_drop", 256'(dut.pkt_cnt_q), 256'd0);
    check_val("state_idle_drop", 256'(gdp_status[31:30]), 256'd0);

    // downstream stall mid-packet
    base = out_cnt;
    send_pkt(md_ones, 12, 1'b1, 1'b1);
    wait_out(base + 4, 200);
    tick();
    pktout_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      @(posedge clk);
      @(negedge clk);
      check_val("stall_no_wr", 256'(pktout_data_wr), 256'd0);
      check_val("stall_status_rdy", 256'(gdp_status[0]), 256'd0);
    end
    tick();
    pktout_ready = 1'b1;
    wait_drain(300);

    // reset pulse mid-packet
    base = out_cnt;
    send_pkt(md_rand, 12, 1'b1, 1'b1);
    wait_out(base + 5, 200);
    #1 rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_val("mid_rst_strobes", {pktout_data_wr, pktout_valid_wr, pktout_valid}, 256'd0);
    check_val("mid_rst_data", 256'(pktout_data), 256'd0);
    check_val("mid_rst_state", 256'(gdp_status[31:30]), 256'd0);
    check_val("mid_rst_fifo", 256'(dut.data_cnt), 256'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send_pkt(md_ones, 3, 1'b1, 1'b1);
    wait_drain(200);

    // almost-full thresholds and overflow, no drain
    pktout_ready = 1'b0;
    for (int i = 0; i < 239; i++) begin
      in_gdp_data = {FLIT_MID, 4'h0, 128'(i)}; in_gdp_data_wr = 1'b1;
      tick();
    end
    in_gdp_data_wr = 1'b0;
    check_val("data_alf_239", 256'(out_gdp_data_alf), 256'd0);
    in_gdp_data_wr = 1'b1;
    tick();
    in_gdp_data_wr = 1'b0;
    check_val("data_alf_240", 256'(out_gdp_data_alf), 256'd1);
    check_val("status_alf_240", 256'(gdp_status[3]), 256'd1);
    check_val("ovf_clear_240", 256'(gdp_status[4]), 256'd0);
    in_gdp_data_wr = 1'b1;
    repeat (60) tick();
    in_gdp_data_wr = 1'b0;
    check_val("ovf_sticky", 256'(gdp_status[4]), 256'd1);
    check_val("data_full", 256'(dut.data_cnt), 256'd256);
    in_gdp_md_wr = 1'b1; in_gdp_phv_wr = 1'b1;
    repeat (2) tick();
    in_gdp_md_wr = 1'b0; in_gdp_phv_wr = 1'b0;
    check_val("md_alf_2", {out_gdp_md_alf, out_gdp_phv_alf}, 256'd0);
    in_gdp_md_wr = 1'b1; in_gdp_phv_wr = 1'b1;
    tick();
    in_gdp_md_wr = 1'b0; in_gdp_phv_wr = 1'b0;
    check_val("md_alf_3", {out_gdp_md_alf, out_gdp_phv_alf}, 256'd3);
    check_val("status_q_alf", 256'(gdp_status[2:1]), 256'd3);
    do_reset();
    check_val("ovf_after_rst", 256'(gdp_status), 256'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gdp.md
Name: gdp

Overview:
- Generic deparser: the transmit-side counterpart of the packet parser at pipeline ingress.
- Takes the processed MD (256 b) and PHV (1024 b) from the last pipeline stage, plus the buffered original packet flits from data_cache.
- Rebuilds the 134-bit flit stream: MD in flits 0–1, PHV in flits 2–9, payload unchanged from flit 10 on. Sends it toward the output port / DMA.
- Store-and-forward: a packet is released only once its tail flit is buffered.

Parameters:
- DATA_AW, 8, log2 depth of the data flit FIFO (256 flits).
- Q_AW, 2, log2 depth of the MD and PHV queues (4 entries each).
- DATA_ALF_GAP, 16, data alf asserts when free data entries <= DATA_ALF_GAP.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_gdp_md  in  256  metadata from pipeline
- in_gdp_md_wr  in  1  MD write strobe
- out_gdp_md_alf  out  1  MD queue almost full (count >= depth-1)
- in_gdp_phv  in  1024  PHV from pipeline
- in_gdp_phv_wr  in  1  PHV write strobe
- out_gdp_phv_alf  out  1  PHV queue almost full (count >= depth-1)
- in_gdp_data  in  134  flit from data_cache; [133:132] 01 head / 11 mid / 10 tail
- in_gdp_data_wr  in  1  flit write strobe
- in_gdp_valid_wr  in  1  packet-complete strobe (with tail or later)
- in_gdp_valid  in  1  packet valid flag
- out_gdp_data_alf  out  1  data FIFO almost full
- pktout_data  out  134  rebuilt flit
- pktout_data_wr  out  1  flit strobe
- pktout_valid_wr  out  1  packet-complete strobe
- pktout_valid  out  1  packet valid
- pktout_ready  in  1  downstream may accept a flit this cycle
- cin_gdp_data / cin_gdp_data_wr / cout_gdp_ready  in/in/out  134/1/1  config ingress, combinational pass-through
- cout_gdp_data / cout_gdp_data_wr / cin_gdp_ready  out/out/in  134/1/1  config egress
- gdp_status  out  32  {state[1:0], 25'b0, ovf_sticky, data_alf, phv_alf, md_alf, pktout_ready}

Behaviour:
- Reset values: all outputs 0, FIFOs and queues empty, pkt_cnt 0, state IDLE, ovf_sticky 0.
- Queues and FIFO:
  - MD queue, PHV queue and data FIFO are first-word-fall-through, written independently.
  - A write to a full queue/FIFO is discarded and sets ovf_sticky, which clears only on reset.
- pkt_cnt (DATA_AW+1 bits):
  - Increments on in_gdp_valid_wr; decrements when a tail flit is popped.
  - Increment and decrement in the same cycle leave it unchanged.
  - The per-packet valid bit is stored in a side FIFO of the same depth as the MD queue.
- States: IDLE, SEND, DROP.
- IDLE:
  - Leaves IDLE when the MD queue, the PHV queue and pkt_cnt are all non-zero.
  - Goes to DROP if head MD[127]==1 or the stored valid bit is 0; otherwise goes to SEND.
  - Flit index fidx resets to 0.
- SEND:
  - Each cycle with pktout_ready=1, pops one flit and drives pktout_data_wr=1 on the next cycle (1-cycle registered latency).
  - Bits [133:128] always come from the stored flit. Bits [127:0] by fidx:
    - fidx 0: MD[127:0]
    - fidx 1: MD[255:128]
    - fidx 2..9: PHV chunk (fidx 2 = PHV[1023:896], down to fidx 9 = PHV[127:0])
    - fidx >= 10: stored payload
  - fidx saturates at 255.
  - pktout_ready=0 means no pop and pktout_data_wr=0; pktout_data holds its last value.
  - Tail flit: the same cycle sets pktout_valid_wr=1 and pktout_valid=1, pops the MD, PHV and valid queues, and returns to IDLE.
- Short packets: a packet shorter than 10 flits ends at its tail; the unused PHV chunks are dropped.
- DROP:
  - Pops one flit per cycle regardless of pktout_ready, with no output.
  - On the tail, pops the queues and returns to IDLE.
- Reset mid-packet: everything flushes immediately and the output strobes drop in the same clock edge; no partial-packet recovery.

Optional Feature:
- GDP_MD_STRIP_EN defined:
  - Flits with fidx 0 and 1 are popped but not emitted.
  - The flit at fidx 2 is emitted with [133:132] forced to 01.
  - A 2-flit packet is dropped entirely, with no output.
- Undefined: MD is emitted as described in Behaviour.

Decomposition:
- Shared package gdp_pkg holds:
  - flit type encodings (HEAD=2'b01, MID=2'b11, TAIL=2'b10);
  - MD_W=256, PHV_W=1024, FLIT_W=134, PHV_FLITS=8, MD_DROP_BIT=127;
  - state encodings.
- One natural sub-module: gdp_fwft_fifo (parameterised width/depth, count output, full/empty), instantiated four times.

Test Plan:
- 12-flit packet, MD=256'h1...1, PHV chunk i=128'hA0+i, payload 128'hC0+fidx -> out flits 0–1 = MD, 2–9 = A2..A9, 10–11 = CA/CB, valid_wr with tail.
- 4-flit packet -> 4 output flits: MD0, MD1, PHV[1023:896], PHV[895:768] with tail type kept; remaining PHV discarded, queues empty after.
- MD[127]=1 on a 6-flit packet followed by a normal 3-flit packet -> no output for the first; second emitted 1 cycle after its turn; pkt_cnt returns to 0.
- pktout_ready low for 5 cycles mid-packet -> no pktout_data_wr during the stall, no flit lost or duplicated, order intact.
- Data FIFO filled to 240/256 -> out_gdp_data_alf=1; 300 writes without drain -> ovf_sticky=1 in gdp_status.
- rst_n pulsed low at flit 5 of SEND -> outputs 0 in the same edge, FIFOs empty, state IDLE, next packet correct.
